axi_slave_wr_ctrl: RTL and testbench

Slave-side AXI write engine that sits between the interconnect and a word-addressed SRAM wrapper. It accepts one AW burst at a time and drains its W beats into SRAM write strobes. It then originates the B response, echoing the interconnect-extended ID (master tag + ID), which the interconnect's B channel routes back to the issuing master. It is the responder end of the AW/W/B path for slaves S0–S5.

---
 rtl/axi_slave_wr_ctrl.sv | 164 ++++++++++++++++
 tb/tb_axi_slave_wr_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_wr_ctrl.sv
// AXI slave write engine: accepts one AW burst, drains W beats into SRAM
// byte-strobed writes, then returns a B response carrying the extended ID.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS  8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS  4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

module axi_slave_wr_ctrl #(
    parameter int MEM_ADDR_BITS = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [`AXI_IDS_BITS-1:0]  awid_i,
    input  logic [`AXI_ADDR_BITS-1:0] awaddr_i,
    input  logic [`AXI_LEN_BITS-1:0]  awlen_i,
    input  logic [`AXI_SIZE_BITS-1:0] awsize_i,
    input  logic [1:0]                awburst_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic [`AXI_DATA_BITS-1:0] wdata_i,
    input  logic [`AXI_STRB_BITS-1:0] wstrb_i,
    input  logic                      wlast_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    output logic [`AXI_IDS_BITS-1:0]  bid_o,
    output logic [`AXI_RESP_BITS-1:0] bresp_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    output logic                      mem_en_o,
    output logic [`AXI_STRB_BITS-1:0] mem_we_o,
    output logic [MEM_ADDR_BITS-1:0]  mem_addr_o,
    output logic [`AXI_DATA_BITS-1:0] mem_wdata_o,
    output logic [1:0]                dbg_state_o
);

    // A transfer on any channel happens in a cycle where valid and ready are
    // both high at the rising edge; valid holds its payload until then.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [`AXI_IDS_BITS-1:0]   r_id;
    logic [MEM_ADDR_BITS-1:0]   r_addr;
    logic [`AXI_LEN_BITS-1:0]   r_len;
    logic [`AXI_LEN_BITS-1:0]   r_cnt;
    logic                       r_incr;
    logic                       r_err;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_cnt_last;
    logic w_beat_end;
    logic w_aw_bad;
    logic w_unused_ok;

    assign w_aw_hs    = (r_state == S_IDLE) && awvalid_i;
    assign w_w_hs     = (r_state == S_WDATA) && wvalid_i;
    assign w_cnt_last = (r_cnt == r_len);
    assign w_beat_end = w_w_hs && (wlast_i || w_cnt_last);
    assign w_aw_bad   = (awsize_i != 3'b010) || (awburst_i[1] == 1'b1);

    assign w_unused_ok = ^{awaddr_i[`AXI_ADDR_BITS-1:MEM_ADDR_BITS+2], awaddr_i[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        awready_o    = 1'b0;
        wready_o     = 1'b0;
        bvalid_o     = 1'b0;
        mem_en_o     = 1'b0;
        mem_we_o     = '0;
        case (r_state)
            S_IDLE: begin
                awready_o = 1'b1;
                if (awvalid_i) begin
                    w_next_state = S_WDATA;
                end
            end
            S_WDATA: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    mem_en_o = 1'b1;
                    // Errored bursts are still drained, just not written.
                    mem_we_o = r_err ? '0 : wstrb_i;
                    if (wlast_i || w_cnt_last) begin
                        w_next_state = S_RESP;
                    end
                end
            end
            S_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id   <= '0;
            r_addr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_incr <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_aw_hs) begin
            r_id   <= awid_i;
            r_addr <= awaddr_i[MEM_ADDR_BITS+1:2];
            r_len  <= awlen_i;
            r_cnt  <= '0;
            r_incr <= (awburst_i == 2'b01);
            r_err  <= w_aw_bad;
        end else if (w_w_hs) begin
            // Word address wraps naturally at the SRAM boundary.
            if (r_incr) begin
                r_addr <= r_addr + 1'b1;
            end
            r_cnt <= r_cnt + 1'b1;
            if (w_beat_end && (wlast_i != w_cnt_last)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bid_o       = r_id;
    assign bresp_o     = (r_state == S_RESP && r_err) ? 2'b10 : 2'b00;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = wdata_i;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
// Scoreboard bench for axi_slave_wr_ctrl: directed bursts, error cases,
// backpressure and mid-burst reset.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS  8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS  4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

module tb_axi_slave_wr_ctrl;
  localparam int MAB = 14;
  localparam int MW  = MAB + 4 + 32;
  localparam int BW  = 8 + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awid_i = '0;
  logic [31:0] awaddr_i = '0;
  logic [3:0]  awlen_i = '0;
  logic [2:0]  awsize_i = '0;
  logic [1:0]  awburst_i = '0;
  logic        awvalid_i = 1'b0;
  logic        awready_o;
  logic [31:0] wdata_i = '0;
  logic [3:0]  wstrb_i = '0;
  logic        wlast_i = 1'b0;
  logic        wvalid_i = 1'b0;
  logic        wready_o;
  logic [7:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i = 1'b0;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [MAB-1:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [1:0]  dbg_state_o;

  logic [MW-1:0] exp_q[$];
  logic [BW-1:0] exp_b_q[$];
  int n_checks = 0;
  int n_errors = 0;

  axi_slave_wr_ctrl #(.MEM_ADDR_BITS(MAB)) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i),
    .awsize_i(awsize_i), .awburst_i(awburst_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard: sampled at the falling edge, mid-cycle
  always @(negedge clk) begin
    if (!rst && mem_en_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL mem_beat: unexpected beat addr=%0h we=%0h", mem_addr_o, mem_we_o);
      end else begin
        logic [MW-1:0] e;
        e = exp_q.pop_front();
        if ({mem_addr_o, mem_we_o, mem_wdata_o} !== e) begin
          n_errors++;
          $display("FAIL mem_beat: got addr=%0h we=%0h data=%0h expected addr=%0h we=%0h data=%0h",
                   mem_addr_o, mem_we_o, mem_wdata_o, e[MW-1 -: MAB], e[35:32], e[31:0]);
        end
      end
    end
    if (!rst && bvalid_o && bready_i) begin
      n_checks++;
      if (exp_b_q.size() == 0) begin
        n_errors++;
        $display("FAIL b_resp: unexpected B id=%0h resp=%0h", bid_o, bresp_o);
      end else begin
        logic [BW-1:0] eb;
        eb = exp_b_q.pop_front();
        if ({bid_o, bresp_o} !== eb) begin
          n_errors++;
          $display("FAIL b_resp: got id=%0h resp=%0h expected id=%0h resp=%0h",
                   bid_o, bresp_o, eb[9:2], eb[1:0]);
        end
      end
    end
  end

  // drivers: entered and left at posedge+1
  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
    awvalid_i = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (awready_o) ok = 1'b1;
      @(posedge clk); #1;
    end
    awvalid_i = 1'b0;
    if (!ok) check("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    wdata_i = data; wstrb_i = strb; wlast_i = last; wvalid_i = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (wready_o) ok = 1'b1;
      @(posedge clk); #1;
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    if (!ok) check("w_timeout", 64'd0, 64'd1);
  endtask

  task automatic recv_b(input int hold);
    logic [7:0] id0;
    logic [1:0] resp0;
    for (int n = 0; n < 50 && !bvalid_o; n++) begin @(posedge clk); #1; end
    check("bvalid_seen", {63'd0, bvalid_o}, 64'd1);
    id0 = bid_o; resp0 = bresp_o;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("b_hold_stable", {52'd0, bvalid_o, id0 ^ bid_o, resp0 ^ bresp_o, awready_o},
            {52'd0, 1'b1, 8'd0, 2'd0, 1'b0});
    end
    bready_i = 1'b1;
    @(posedge clk); #1;
    bready_i = 1'b0;
    check("awready_after_b", {63'd0, awready_o}, 64'd1);
  endtask

  function automatic logic [MW-1:0] mk(input logic [MAB-1:0] a, input logic [3:0] we,
                                       input logic [31:0] d);
    return {a, we, d};
  endfunction

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", {63'd0, awready_o}, 64'd1);
    check("rst_outputs", {40'd0, wready_o, bvalid_o, bid_o, bresp_o, mem_en_o, mem_we_o},
          64'd0);
    check("rst_mem_addr", {50'd0, mem_addr_o}, 64'd0);
    check("rst_state", {62'd0, dbg_state_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single write
    exp_q.push_back(mk(14'h0040, 4'hF, 32'hDEADBEEF));
    exp_b_q.push_back({8'h12, 2'b00});
    send_aw(8'h12, 32'h100, 4'd0, 3'b010, 2'b01);
    check("wready_n_plus_1", {63'd0, wready_o}, 64'd1);
    send_w(32'hDEADBEEF, 4'hF, 1'b1, 0);
    check("bvalid_m_plus_1", {63'd0, bvalid_o}, 64'd1);
    check("single_bid_bresp", {54'd0, bid_o, bresp_o}, {54'd0, 8'h12, 2'b00});
    recv_b(0);

    // INCR burst wrapping at the top of SRAM
    exp_q.push_back(mk(14'h3FFE, 4'h1, 32'h11111111));
    exp_q.push_back(mk(14'h3FFF, 4'h3, 32'h22222222));
    exp_q.push_back(mk(14'h0000, 4'hF, 32'h33333333));
    exp_q.push_back(mk(14'h0001, 4'h8, 32'h44444444));
    exp_b_q.push_back({8'h34, 2'b00});
    send_aw(8'h34, 32'hFFF8, 4'd3, 3'b010, 2'b01);
    send_w(32'h11111111, 4'h1, 1'b0, 0);
    send_w(32'h22222222, 4'h3, 1'b0, 1);
    send_w(32'h33333333, 4'hF, 1'b0, 2);
    send_w(32'h44444444, 4'h8, 1'b1, 0);
    recv_b(0);

    // FIXED burst with B backpressure
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(14'h0008, 4'hF, 32'hA0 + i));
    exp_b_q.push_back({8'h56, 2'b00});
    send_aw(8'h56, 32'h20, 4'd2, 3'b010, 2'b00);
    for (int i = 0; i < 3; i++) send_w(32'hA0 + i, 4'hF, (i == 2), 0);
    recv_b(5);

    // early wlast
    exp_q.push_back(mk(14'h0004, 4'hF, 32'hB0));
    exp_q.push_back(mk(14'h0005, 4'hF, 32'hB1));
    exp_b_q.push_back({8'h61, 2'b10});
    send_aw(8'h61, 32'h10, 4'd3, 3'b010, 2'b01);
    send_w(32'hB0, 4'hF, 1'b0, 0);
    send_w(32'hB1, 4'hF, 1'b1, 0);
    check("early_wlast_wready", {63'd0, wready_o}, 64'd0);
    recv_b(0);

    // missing wlast
    exp_q.push_back(mk(14'h0004, 4'h6, 32'hC0));
    exp_q.push_back(mk(14'h0005, 4'h6, 32'hC1));
    exp_b_q.push_back({8'h62, 2'b10});
    send_aw(8'h62, 32'h10, 4'd1, 3'b010, 2'b01);
    send_w(32'hC0, 4'h6, 1'b0, 0);
    send_w(32'hC1, 4'h6, 1'b0, 0);
    check("missing_wlast_bvalid", {63'd0, bvalid_o}, 64'd1);
    recv_b(0);

    // unsupported size: writes suppressed
    exp_q.push_back(mk(14'h0010, 4'h0, 32'hD0));
    exp_q.push_back(mk(14'h0011, 4'h0, 32'hD1));
    exp_b_q.push_back({8'h63, 2'b10});
    send_aw(8'h63, 32'h40, 4'd1, 3'b001, 2'b01);
    send_w(32'hD0, 4'hF, 1'b0, 0);
    send_w(32'hD1, 4'hF, 1'b1, 0);
    recv_b(0);

    // unsupported burst type
    exp_q.push_back(mk(14'h0020, 4'h0, 32'hE0));
    exp_b_q.push_back({8'h64, 2'b10});
    send_aw(8'h64, 32'h80, 4'd0, 3'b010, 2'b10);
    send_w(32'hE0, 4'hF, 1'b1, 0);
    recv_b(0);

    // reset during beat 2 of a len=3 burst
    exp_q.push_back(mk(14'h0080, 4'hF, 32'hF0));
    send_aw(8'h70, 32'h200, 4'd3, 3'b010, 2'b01);
    send_w(32'hF0, 4'hF, 1'b0, 0);
    wdata_i = 32'hF1; wstrb_i = 4'hF; wvalid_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", {56'd0, awready_o, wready_o, mem_en_o, bvalid_o, mem_we_o},
          {56'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    @(posedge clk); #1;
    wvalid_i = 1'b0;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_no_b", {63'd0, bvalid_o}, 64'd0);

    exp_q.push_back(mk(14'h00C0, 4'h5, 32'h12345678));
    exp_b_q.push_back({8'h71, 2'b00});
    send_aw(8'h71, 32'h300, 4'd0, 3'b010, 2'b01);
    send_w(32'h12345678, 4'h5, 1'b1, 0);
    recv_b(0);

    repeat (2) @(posedge clk);
    #1;
    check("queues_drained", {32'd0, exp_q.size() + exp_b_q.size()}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
